// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for an N-bit shift-and-add multiplier datapath.
// Latency: LOAD 1 cycle, RUN up to N cycles, DONE 1 cycle (N+2 cycles for a full run).
// Backpressure: none; start is only sampled in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - request a multiply (honoured in IDLE or DONE only)
//   mplr_lsb          - bit 0 of the shifting multiplier register
//   mplr_zero         - multiplier register currently reads zero
//   load              - load multiplier and multiplicand registers
//   acc_clr           - clear the accumulator
//   shift_en          - shift multiplier right, multiplicand left
//   add_en            - accumulator += current (pre-shift) multiplicand
//   busy              - operation in progress (LOAD or RUN)
//   done              - one-cycle pulse, product valid in the accumulator
//   step_cnt          - shift steps completed in the current/last operation
module shift_add_mult_ctrl #(
    parameter int N          = 8,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int CW        = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mplr_lsb,
    input  logic          mplr_zero,
    output logic          load,
    output logic          acc_clr,
    output logic          shift_en,
    output logic          add_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] step_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] step_q;
    logic [CW-1:0] step_d;

    logic in_run;
    logic early_stop;
    logic do_step;
    logic last_step;

    assign in_run     = (state_q == S_RUN);

    // With early exit, a zero multiplier means every remaining partial
    // product is zero, so the RUN cycle that sees it performs no step.
    assign early_stop = EARLY_EXIT && mplr_zero;
    assign do_step    = in_run && !early_stop;
    assign last_step  = (step_q == LAST_STEP);

    // Next-state and step counter.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                step_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (early_stop) begin
                    state_d = S_DONE;
                end else begin
                    step_d = step_q + CW'(1);
                    if (last_step) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Back-to-back: a start seen in DONE skips IDLE entirely.
                state_d = start ? S_LOAD : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // State-only decodes: these come straight off the state flops, so an
    // asynchronous reset forces them low without waiting for a clock.
    assign load     = (state_q == S_LOAD);
    assign acc_clr  = (state_q == S_LOAD);
    assign busy     = (state_q == S_LOAD) || in_run;
    assign done     = (state_q == S_DONE);

    // Add and shift fire on the same edge, so the accumulator picks up the
    // multiplicand before it moves left. Both are gated by RUN, which keeps
    // them mutually exclusive with load.
    assign shift_en = do_step;
    assign add_en   = do_step && mplr_lsb;

    assign step_cnt = step_q;

endmodule
